// File: rtl/credit_vc_receiver.sv
// Credit-based virtual-channel receiver: one small FIFO per VC, drained through a
// single round-robin arbitrated valid/ack output that returns one credit per transfer.
module credit_vc_receiver #(
   parameter int VC_W  = 3,
   parameter int X_W   = 2,
   parameter int Y_W   = 2,
   parameter int D_W   = 128,
   parameter int DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VC_W-1:0]      vc_target,
   input  logic [X_W+Y_W-1:0]   in_addr,
   input  logic [D_W-1:0]       in_data,
   output logic [VC_W-1:0]      vc_credit_gnt,
   output logic                 o_v,
   output logic [X_W-1:0]       o_x,
   output logic [Y_W-1:0]       o_y,
   output logic [D_W-1:0]       o_data,
   output logic [VC_W-1:0]      o_vc,
   input  logic                 i_ack,
   output logic                 err,
   output logic                 idle
);

   localparam int A_W   = X_W + Y_W;
   localparam int E_W   = A_W + D_W;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int SUM_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_VC_C  = IDX_W'(VC_W - 1);

   logic [E_W-1:0]   mem_q    [VC_W][DEPTH];
   logic [E_W-1:0]   mem_d    [VC_W][DEPTH];
   logic [CNT_W-1:0] count_q  [VC_W];
   logic [CNT_W-1:0] count_d  [VC_W];
   logic [PTR_W-1:0] rd_ptr_q [VC_W];
   logic [PTR_W-1:0] rd_ptr_d [VC_W];
   logic [PTR_W-1:0] wr_ptr_q [VC_W];
   logic [PTR_W-1:0] wr_ptr_d [VC_W];
   logic [IDX_W-1:0] rr_q, rr_d, sel_q, sel_d, arb_idx, scan_idx;
   logic [SUM_W-1:0] scan_sum;
   logic             o_v_q, o_v_d, err_q, err_d, idle_q, idle_d;
   logic [VC_W-1:0]  o_vc_q, o_vc_d, gnt_q, gnt_d, wr_en, pop_en;
   logic [A_W-1:0]   o_addr_q, o_addr_d;
   logic [D_W-1:0]   o_data_q, o_data_d;
   logic             multi_hot, xfer, ovf, arb_found;

   // A full VC refuses a write even when it is popped this cycle: its credit is still outstanding.
   always_comb begin
      multi_hot = (vc_target & (vc_target - VC_W'(1))) != {VC_W{1'b0}};
      xfer      = o_v_q & i_ack;
      ovf       = 1'b0;
      mem_d     = mem_q;
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      idle_d    = 1'b1;
      for (int k = 0; k < VC_W; k++) begin
         wr_en[k]  = !rst && !multi_hot && vc_target[k] && (count_q[k] != FULL_C);
         pop_en[k] = xfer && (sel_q == IDX_W'(k));
         ovf       = ovf | (!rst && !multi_hot && vc_target[k] && (count_q[k] == FULL_C));
         if (wr_en[k]) begin
            mem_d[k][wr_ptr_q[k]] = {in_addr, in_data};
            wr_ptr_d[k] = (wr_ptr_q[k] == LAST_PTR_C) ? {PTR_W{1'b0}} : wr_ptr_q[k] + PTR_W'(1);
         end else begin
            wr_ptr_d[k] = wr_ptr_q[k];
         end
         if (pop_en[k]) begin
            rd_ptr_d[k] = (rd_ptr_q[k] == LAST_PTR_C) ? {PTR_W{1'b0}} : rd_ptr_q[k] + PTR_W'(1);
         end else begin
            rd_ptr_d[k] = rd_ptr_q[k];
         end
         count_d[k] = count_q[k] + CNT_W'(wr_en[k]) - CNT_W'(pop_en[k]);
         idle_d     = idle_d & (count_d[k] == {CNT_W{1'b0}});
      end
      err_d = err_q | (!rst && multi_hot) | ovf;
   end

   // Round-robin search from rr_q; only registered counts are seen, so there is no write bypass.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = rr_q;
      scan_sum  = {SUM_W{1'b0}};
      scan_idx  = rr_q;
      for (int i = 0; i < VC_W; i++) begin
         scan_sum = {1'b0, rr_q} + SUM_W'(i);
         if (scan_sum >= SUM_W'(VC_W)) begin
            scan_sum = scan_sum - SUM_W'(VC_W);
         end else begin
            scan_sum = scan_sum;
         end
         scan_idx = scan_sum[IDX_W-1:0];
         if (!arb_found && (count_q[scan_idx] != {CNT_W{1'b0}})) begin
            arb_found = 1'b1;
            arb_idx   = scan_idx;
         end else begin
            arb_found = arb_found;
         end
      end
   end

   always_comb begin
      o_v_d    = o_v_q;
      sel_d    = sel_q;
      o_vc_d   = o_vc_q;
      o_addr_d = o_addr_q;
      o_data_d = o_data_q;
      rr_d     = rr_q;
      gnt_d    = xfer ? o_vc_q : {VC_W{1'b0}};
      if (o_v_q) begin
         if (i_ack) begin
            o_v_d = 1'b0;
            rr_d  = (sel_q == LAST_VC_C) ? {IDX_W{1'b0}} : sel_q + IDX_W'(1);
         end else begin
            o_v_d = 1'b1;
         end
      end else if (arb_found) begin
         o_v_d  = 1'b1;
         sel_d  = arb_idx;
         o_vc_d = VC_W'(1) << arb_idx;
         for (int k = 0; k < VC_W; k++) begin
            if (arb_idx == IDX_W'(k)) begin
               {o_addr_d, o_data_d} = mem_q[k][rd_ptr_q[k]];
            end else begin
               o_addr_d = o_addr_d;
            end
         end
      end else begin
         o_v_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < VC_W; k++) begin
            count_q[k]  <= {CNT_W{1'b0}};
            rd_ptr_q[k] <= {PTR_W{1'b0}};
            wr_ptr_q[k] <= {PTR_W{1'b0}};
         end
         rr_q     <= {IDX_W{1'b0}};
         sel_q    <= {IDX_W{1'b0}};
         o_v_q    <= 1'b0;
         o_vc_q   <= {VC_W{1'b0}};
         o_addr_q <= {A_W{1'b0}};
         o_data_q <= {D_W{1'b0}};
         gnt_q    <= {VC_W{1'b0}};
         err_q    <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         rr_q     <= rr_d;
         sel_q    <= sel_d;
         o_v_q    <= o_v_d;
         o_vc_q   <= o_vc_d;
         o_addr_q <= o_addr_d;
         o_data_q <= o_data_d;
         gnt_q    <= gnt_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
      end
   end

   // Storage needs no reset: validity is tracked by the counts alone.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign vc_credit_gnt = gnt_q;
   assign o_v           = o_v_q;
   assign o_x           = o_addr_q[A_W-1:Y_W];
   assign o_y           = o_addr_q[Y_W-1:0];
   assign o_data        = o_data_q;
   assign o_vc          = o_vc_q;
   assign err           = err_q;
   assign idle          = idle_q;

endmodule

// File: tb/tb_credit_vc_receiver.sv
// Self-checking bench for credit_vc_receiver: per-scenario tasks plus a flit/credit scoreboard.
module tb_credit_vc_receiver;
   localparam int VC_W = 3, X_W = 2, Y_W = 2, D_W = 128, DEPTH = 2;

   typedef struct packed {
      logic [VC_W-1:0]    vc;
      logic [X_W+Y_W-1:0] addr;
      logic [D_W-1:0]     data;
   } flit_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [VC_W-1:0]      vc_target = '0;
   logic [X_W+Y_W-1:0]   in_addr = '0;
   logic [D_W-1:0]       in_data = '0;
   logic [VC_W-1:0]      vc_credit_gnt;
   logic                 o_v;
   logic [X_W-1:0]       o_x;
   logic [Y_W-1:0]       o_y;
   logic [D_W-1:0]       o_data;
   logic [VC_W-1:0]      o_vc;
   logic                 i_ack = 1'b0;
   logic                 err;
   logic                 idle;

   int              vec_cnt = 0;
   int              err_cnt = 0;
   flit_t           sb[$];
   logic [VC_W-1:0] got_vc[$];
   logic [VC_W-1:0] exp_gnt = '0;
   bit              mon_en = 1'b0;
   bit              mon_hit;

   credit_vc_receiver #(.VC_W(VC_W), .X_W(X_W), .Y_W(Y_W), .D_W(D_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .vc_target(vc_target), .in_addr(in_addr), .in_data(in_data),
      .vc_credit_gnt(vc_credit_gnt), .o_v(o_v), .o_x(o_x), .o_y(o_y), .o_data(o_data),
      .o_vc(o_vc), .i_ack(i_ack), .err(err), .idle(idle)
   );

   always #5 clk = ~clk;

   // Scoreboard: every cycle checks the credit pulse owed by the previous transfer and matches flits.
   always @(negedge clk) begin
      if (mon_en) begin
         vec_cnt++;
         if (vc_credit_gnt !== exp_gnt) begin
            err_cnt++;
            $display("FAIL gnt_pulse: got %b expected %b at %0t", vc_credit_gnt, exp_gnt, $time);
         end
         if (o_v === 1'b1 && i_ack === 1'b1 && rst === 1'b0) begin
            exp_gnt = o_vc;
            got_vc.push_back(o_vc);
            mon_hit = 1'b0;
            vec_cnt++;
            for (int i = 0; i < sb.size(); i++) begin
               if (!mon_hit && sb[i].vc == o_vc) begin
                  mon_hit = 1'b1;
                  if ({o_x, o_y} !== sb[i].addr || o_data !== sb[i].data) begin
                     err_cnt++;
                     $display("FAIL flit_fields: got addr %h data %h expected addr %h data %h",
                              {o_x, o_y}, o_data, sb[i].addr, sb[i].data);
                  end
                  sb.delete(i);
               end
            end
            if (!mon_hit) begin
               err_cnt++;
               $display("FAIL unexpected_flit: got vc %b, expected none pending", o_vc);
            end
         end else begin
            exp_gnt = '0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      vc_target = '0;
      tick();
      rst = 1'b0;
      sb.delete();
      got_vc.delete();
   endtask

   task automatic send(input logic [VC_W-1:0] tgt, input logic [X_W+Y_W-1:0] addr,
                       input logic [D_W-1:0] data, input bit accept);
      flit_t f;
      vc_target = tgt;
      in_addr   = addr;
      in_data   = data;
      f.vc = tgt; f.addr = addr; f.data = data;
      if (accept) sb.push_back(f);
      tick();
      vc_target = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1; vc_target = 3'b001; in_addr = 4'hF; i_ack = 1'b0;
      tick();
      rst = 1'b0; vc_target = '0;
      vec_cnt++; if (o_v !== 1'b0) begin err_cnt++; $display("FAIL reset_ov: got %b expected 0", o_v); end
      vec_cnt++; if (vc_credit_gnt !== 3'b000) begin err_cnt++; $display("FAIL reset_gnt: got %b expected 000", vc_credit_gnt); end
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL reset_err: got %b expected 0", err); end
      vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL reset_idle: got %b expected 1", idle); end
      tick(); tick();
      vec_cnt++; if (o_v !== 1'b0 || idle !== 1'b1) begin err_cnt++; $display("FAIL reset_ignores_target: got o_v %b idle %b expected 0 1", o_v, idle); end
      mon_en = 1'b1;
   endtask

   task automatic test_single();
      i_ack = 1'b1;
      send(3'b010, 4'b0111, 128'hA5, 1'b1);
      vec_cnt++; if (o_v !== 1'b0) begin err_cnt++; $display("FAIL single_no_bypass: got o_v %b expected 0", o_v); end
      tick();
      vec_cnt++; if (o_v !== 1'b1) begin err_cnt++; $display("FAIL single_ov: got %b expected 1", o_v); end
      vec_cnt++; if (o_x !== 2'd1 || o_y !== 2'd3) begin err_cnt++; $display("FAIL single_xy: got %0d,%0d expected 1,3", o_x, o_y); end
      vec_cnt++; if (o_vc !== 3'b010) begin err_cnt++; $display("FAIL single_vc: got %b expected 010", o_vc); end
      vec_cnt++; if (o_data !== 128'hA5) begin err_cnt++; $display("FAIL single_data: got %h expected a5", o_data); end
      tick();
      vec_cnt++; if (vc_credit_gnt !== 3'b010) begin err_cnt++; $display("FAIL single_gnt: got %b expected 010", vc_credit_gnt); end
      vec_cnt++; if (idle !== 1'b1 || o_v !== 1'b0) begin err_cnt++; $display("FAIL single_idle: got idle %b o_v %b expected 1 0", idle, o_v); end
      tick();
      vec_cnt++; if (vc_credit_gnt !== 3'b000) begin err_cnt++; $display("FAIL single_gnt_once: got %b expected 000", vc_credit_gnt); end
      i_ack = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [D_W-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      i_ack = 1'b0;
      send(3'b001, 4'b1001, d, 1'b1);
      tick();
      for (int c = 0; c < 5; c++) begin
         vec_cnt++;
         if (o_v !== 1'b1 || o_vc !== 3'b001 || o_x !== 2'd2 || o_y !== 2'd1 || o_data !== d || vc_credit_gnt !== 3'b000) begin
            err_cnt++;
            $display("FAIL bp_hold: cycle %0d got v %b vc %b x %0d y %0d gnt %b expected 1 001 2 1 000", c, o_v, o_vc, o_x, o_y, vc_credit_gnt);
         end
         tick();
      end
      i_ack = 1'b1;
      tick();
      vec_cnt++; if (vc_credit_gnt !== 3'b001 || o_v !== 1'b0) begin err_cnt++; $display("FAIL bp_release: got gnt %b o_v %b expected 001 0", vc_credit_gnt, o_v); end
      i_ack = 1'b0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [VC_W-1:0] want;
      do_reset();
      i_ack = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int v = 0; v < VC_W; v++)
            send(VC_W'(1) << v, 4'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b1);
      i_ack = 1'b1;
      for (int t = 0; t < 40 && got_vc.size() < 6; t++) tick();
      vec_cnt++; if (got_vc.size() != 6) begin err_cnt++; $display("FAIL rr_count: got %0d flits expected 6", got_vc.size()); end
      for (int i = 0; i < got_vc.size() && i < 6; i++) begin
         want = VC_W'(1) << (i % 3);
         vec_cnt++; if (got_vc[i] !== want) begin err_cnt++; $display("FAIL rr_order: slot %0d got %b expected %b", i, got_vc[i], want); end
      end
      tick(); tick();
      vec_cnt++; if (idle !== 1'b1 || sb.size() != 0) begin err_cnt++; $display("FAIL rr_drain: got idle %b pending %0d expected 1 0", idle, sb.size()); end
      i_ack = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      i_ack = 1'b0;
      send(3'b100, 4'h1, 128'h111, 1'b1);
      send(3'b100, 4'h2, 128'h222, 1'b1);
      vec_cnt++; if (err !== 1'b0) begin err_cnt++; $display("FAIL ovf_no_err: got %b expected 0", err); end
      send(3'b100, 4'h3, 128'h333, 1'b0);
      vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL ovf_err: got %b expected 1", err); end
      i_ack = 1'b1;
      for (int t = 0; t < 30 && got_vc.size() < 2; t++) tick();
      repeat (4) tick();
      vec_cnt++; if (got_vc.size() != 2) begin err_cnt++; $display("FAIL ovf_delivered: got %0d expected 2", got_vc.size()); end
      vec_cnt++; if (idle !== 1'b1 || err !== 1'b1) begin err_cnt++; $display("FAIL ovf_end: got idle %b err %b expected 1 1", idle, err); end
      // Full VC written while it is being popped: the write is still dropped.
      do_reset();
      i_ack = 1'b0;
      send(3'b100, 4'h4, 128'h444, 1'b1);
      send(3'b100, 4'h5, 128'h555, 1'b1);
      vec_cnt++; if (o_v !== 1'b1 || err !== 1'b0) begin err_cnt++; $display("FAIL ovf2_setup: got o_v %b err %b expected 1 0", o_v, err); end
      vc_target = 3'b100; in_addr = 4'h6; in_data = 128'h666; i_ack = 1'b1;
      tick();
      vc_target = '0;
      vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL ovf2_err: got %b expected 1", err); end
      for (int t = 0; t < 30 && got_vc.size() < 2; t++) tick();
      repeat (4) tick();
      vec_cnt++; if (got_vc.size() != 2 || idle !== 1'b1) begin err_cnt++; $display("FAIL ovf2_delivered: got %0d idle %b expected 2 1", got_vc.size(), idle); end
      i_ack = 1'b0;
   endtask

   task automatic test_malformed();
      do_reset();
      i_ack = 1'b0;
      send(3'b011, 4'hA, 128'hBAD, 1'b0);
      vec_cnt++; if (err !== 1'b1) begin err_cnt++; $display("FAIL malformed_err: got %b expected 1", err); end
      vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("FAIL malformed_idle: got %b expected 1", idle); end
      tick(); tick();
      vec_cnt++; if (idle !== 1'b1 || o_v !== 1'b0) begin err_cnt++; $display("FAIL malformed_nowrite: got idle %b o_v %b expected 1 0", idle, o_v); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      i_ack = 1'b0;
      send(3'b110, 4'h0, 128'h0, 1'b0);
      send(3'b001, 4'h1, 128'hC0, 1'b1);
      send(3'b010, 4'h2, 128'hC1, 1'b1);
      send(3'b100, 4'h3, 128'hC2, 1'b1);
      vec_cnt++; if (o_v !== 1'b1 || idle !== 1'b0 || err !== 1'b1) begin err_cnt++; $display("FAIL midrst_setup: got o_v %b idle %b err %b expected 1 0 1", o_v, idle, err); end
      rst = 1'b1; i_ack = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      vec_cnt++; if (o_v !== 1'b0 || idle !== 1'b1 || err !== 1'b0) begin err_cnt++; $display("FAIL midrst_state: got o_v %b idle %b err %b expected 0 1 0", o_v, idle, err); end
      repeat (10) tick();
      vec_cnt++; if (o_v !== 1'b0 || got_vc.size() != 0) begin err_cnt++; $display("FAIL midrst_flushed: got o_v %b delivered %0d expected 0 0", o_v, got_vc.size()); end
      i_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_overflow();
      test_malformed();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
